// File: rtl/hwpe_stream_merge_buffered_if.sv
// HWPE-Stream handshake bundle: valid/ready plus data and byte strobes.
// source/sink are the canonical modports; master/slave are aliases for the same directions.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) ();

    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;

    modport source (output valid, output data, output strb, input ready);
    modport sink   (input valid, input data, input strb, output ready);
    modport master (output valid, output data, output strb, input ready);
    modport slave  (input valid, input data, input strb, output ready);

endinterface

// File: rtl/hwpe_stream_merge_buffered.sv
// Merges NB_IN_STREAMS narrow stream lanes, each with its own small FIFO, into one wide stream.
// A wide beat is presented once every lane holds at least one beat; lane 0 maps to the LSBs.
module hwpe_stream_merge_buffered #(
    parameter int unsigned NB_IN_STREAMS  = 2,
    parameter int unsigned DATA_WIDTH_OUT = 128,
    parameter int unsigned LANE_DEPTH     = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    hwpe_stream_intf_stream.sink   push_i [NB_IN_STREAMS-1:0],
    hwpe_stream_intf_stream.source pop_o
);

    localparam int unsigned DATA_WIDTH_IN = DATA_WIDTH_OUT / NB_IN_STREAMS;
    localparam int unsigned STRB_WIDTH_IN = DATA_WIDTH_IN / 8;
    localparam int unsigned PTR_W         = (LANE_DEPTH > 1) ? $clog2(LANE_DEPTH) : 1;
    localparam int unsigned CNT_W         = $clog2(LANE_DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(LANE_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LANE_DEPTH);

    if (NB_IN_STREAMS < 1) begin : gen_bad_nb
        $fatal(1, "hwpe_stream_merge_buffered: NB_IN_STREAMS must be >= 1");
    end
    if (LANE_DEPTH < 1) begin : gen_bad_depth
        $fatal(1, "hwpe_stream_merge_buffered: LANE_DEPTH must be >= 1");
    end
    if ((DATA_WIDTH_OUT % NB_IN_STREAMS) != 0) begin : gen_bad_div
        $fatal(1, "hwpe_stream_merge_buffered: DATA_WIDTH_OUT not divisible by NB_IN_STREAMS");
    end
    if ((DATA_WIDTH_IN == 0) || ((DATA_WIDTH_IN % 8) != 0)) begin : gen_bad_width
        $fatal(1, "hwpe_stream_merge_buffered: lane width must be a non-zero multiple of 8");
    end

    logic [NB_IN_STREAMS-1:0]                    lane_nonempty_s;
    logic [NB_IN_STREAMS-1:0][DATA_WIDTH_IN-1:0] head_data_s;
    logic [NB_IN_STREAMS-1:0][STRB_WIDTH_IN-1:0] head_strb_s;
    logic                                        pop_valid_s;
    logic                                        pop_fire_s;

    // Clear masks valid so no pop can coincide with the lane reset.
    assign pop_valid_s = (&lane_nonempty_s) && !clear_i;
    assign pop_fire_s  = pop_valid_s && pop_o.ready;
    assign pop_o.valid = pop_valid_s;
    assign pop_o.data  = head_data_s;
    assign pop_o.strb  = head_strb_s;

    for (genvar ii = 0; ii < NB_IN_STREAMS; ii++) begin : gen_lane
        logic [DATA_WIDTH_IN-1:0] data_q [LANE_DEPTH];
        logic [STRB_WIDTH_IN-1:0] strb_q [LANE_DEPTH];
        logic [PTR_W-1:0]         wptr_q, wptr_d;
        logic [PTR_W-1:0]         rptr_q, rptr_d;
        logic [CNT_W-1:0]         cnt_q, cnt_d;
        logic                     ready_s;
        logic                     push_fire_s;

        // Ready looks only at the own count, never at the output side.
        assign ready_s             = (cnt_q < CNT_MAX) && !clear_i;
        assign push_fire_s         = push_i[ii].valid && ready_s;
        assign push_i[ii].ready    = ready_s;
        assign lane_nonempty_s[ii] = (cnt_q != CNT_ZERO);
        assign head_data_s[ii]     = data_q[rptr_q];
        assign head_strb_s[ii]     = strb_q[rptr_q];

        // Next-state for pointers and occupancy; pointers wrap explicitly for non-power-of-two depths.
        always_comb begin
            wptr_d = wptr_q;
            rptr_d = rptr_q;
            cnt_d  = cnt_q;
            if (clear_i) begin
                wptr_d = PTR_ZERO;
                rptr_d = PTR_ZERO;
                cnt_d  = CNT_ZERO;
            end else begin
                if (push_fire_s) begin
                    wptr_d = (wptr_q == PTR_LAST) ? PTR_ZERO : (wptr_q + PTR_ONE);
                end else begin
                    wptr_d = wptr_q;
                end
                if (pop_fire_s) begin
                    rptr_d = (rptr_q == PTR_LAST) ? PTR_ZERO : (rptr_q + PTR_ONE);
                end else begin
                    rptr_d = rptr_q;
                end
                case ({push_fire_s, pop_fire_s})
                    2'b10:   cnt_d = cnt_q + CNT_ONE;
                    2'b01:   cnt_d = cnt_q - CNT_ONE;
                    default: cnt_d = cnt_q;
                endcase
            end
        end

        // Pointer and occupancy registers.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                wptr_q <= PTR_ZERO;
                rptr_q <= PTR_ZERO;
                cnt_q  <= CNT_ZERO;
            end else begin
                wptr_q <= wptr_d;
                rptr_q <= rptr_d;
                cnt_q  <= cnt_d;
            end
        end

        // Lane storage; contents survive a clear, only the pointers are reset.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                data_q <= '{default: '0};
                strb_q <= '{default: '0};
            end else if (push_fire_s) begin
                data_q[wptr_q] <= push_i[ii].data;
                strb_q[wptr_q] <= push_i[ii].strb;
            end
        end
    end

endmodule

// File: tb/tb_hwpe_stream_merge_buffered.sv
// Scoreboard bench: two-lane depth-2 instance and four-lane depth-1 instance with directed vectors.
module tb_hwpe_stream_merge_buffered;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Instance A: 2 lanes x 32 bit, depth 2
    logic             a_clear, a_pop_ready, a_pop_valid;
    logic [1:0]       a_valid, a_ready;
    logic [1:0][31:0] a_data;
    logic [1:0][3:0]  a_strb;
    logic [63:0]      a_pop_data;
    logic [7:0]       a_pop_strb;

    hwpe_stream_intf_stream #(.DATA_WIDTH(32)) a_push [1:0] ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(64)) a_pop ();

    for (genvar g = 0; g < 2; g++) begin : g_a
        assign a_push[g].valid = a_valid[g];
        assign a_push[g].data  = a_data[g];
        assign a_push[g].strb  = a_strb[g];
        assign a_ready[g]      = a_push[g].ready;
    end
    assign a_pop.ready = a_pop_ready;
    assign a_pop_valid = a_pop.valid;
    assign a_pop_data  = a_pop.data;
    assign a_pop_strb  = a_pop.strb;

    hwpe_stream_merge_buffered #(.NB_IN_STREAMS(2), .DATA_WIDTH_OUT(64), .LANE_DEPTH(2)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(a_clear), .push_i(a_push), .pop_o(a_pop)
    );

    // Instance B: 4 lanes x 32 bit, depth 1
    logic             b_clear, b_pop_ready, b_pop_valid;
    logic [3:0]       b_valid, b_ready;
    logic [3:0][31:0] b_data;
    logic [3:0][3:0]  b_strb;
    logic [127:0]     b_pop_data;
    logic [15:0]      b_pop_strb;

    hwpe_stream_intf_stream #(.DATA_WIDTH(32))  b_push [3:0] ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(128)) b_pop ();

    for (genvar g = 0; g < 4; g++) begin : g_b
        assign b_push[g].valid = b_valid[g];
        assign b_push[g].data  = b_data[g];
        assign b_push[g].strb  = b_strb[g];
        assign b_ready[g]      = b_push[g].ready;
    end
    assign b_pop.ready = b_pop_ready;
    assign b_pop_valid = b_pop.valid;
    assign b_pop_data  = b_pop.data;
    assign b_pop_strb  = b_pop.strb;

    hwpe_stream_merge_buffered #(.NB_IN_STREAMS(4), .DATA_WIDTH_OUT(128), .LANE_DEPTH(1)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(b_clear), .push_i(b_push), .pop_o(b_pop)
    );

    // Scoreboard state
    logic [71:0]  a_exp_q [$];
    logic [143:0] b_exp_q [$];
    logic [35:0]  a_plan0 [$];
    logic [35:0]  a_plan1 [$];
    int a_cyc, a_out_cnt, a_first_cyc, a_last_cyc;
    int b_cyc, b_out_cnt, b_first_cyc, b_prev_cyc;
    logic a_mon_en = 1'b0;
    logic b_mon_en = 1'b0;
    int   a_tid = 0;
    logic a_stall_prev = 1'b0;
    logic [71:0] a_prev_out;

    task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] bdat(input int l, input int k);
        return 32'hC000_0000 + 32'(l * 256) + 32'(k);
    endfunction

    function automatic logic [3:0] bstr(input int l, input int k);
        return 4'(k + l + 1);
    endfunction

    // Monitor A: compare every handshake against the queue, check hold behaviour under stall
    always @(negedge clk) begin
        if (a_mon_en) begin
            if (a_stall_prev && !a_clear) begin
                chk("a_hold_valid", a_pop_valid, 1'b1);
                chk("a_hold_data", {a_pop_strb, a_pop_data}, a_prev_out);
            end
            if (a_pop_valid && a_pop_ready) begin
                if (a_exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL a_extra_out: got %0h expected none", {a_pop_strb, a_pop_data});
                end else begin
                    chk("a_out", {a_pop_strb, a_pop_data}, a_exp_q.pop_front());
                    a_out_cnt++;
                    if (a_first_cyc < 0) a_first_cyc = a_cyc;
                    a_last_cyc = a_cyc;
                end
            end
            a_stall_prev = a_pop_valid && !a_pop_ready;
            a_prev_out   = {a_pop_strb, a_pop_data};
        end
    end

    // Monitor B: ordering plus spacing between consecutive wide beats
    always @(negedge clk) begin
        if (b_mon_en && b_pop_valid && b_pop_ready) begin
            if (b_exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL b_extra_out: got %0h expected none", {b_pop_strb, b_pop_data});
            end else begin
                chk("b_out", {b_pop_strb, b_pop_data}, b_exp_q.pop_front());
                if (b_out_cnt > 0) chk("b_spacing", b_cyc - b_prev_cyc, 2);
                else b_first_cyc = b_cyc;
                b_prev_cyc = b_cyc;
                b_out_cnt++;
            end
        end
    end

    task automatic run_a(input int st0, input int st1, input int bp_lo, input int bp_hi, input int maxc);
        int   c = 0;
        logic acc0, acc1;
        a_out_cnt = 0; a_first_cyc = -1; a_last_cyc = -1;
        while ((c < maxc) && ((a_plan0.size() != 0) || (a_plan1.size() != 0) || (a_exp_q.size() != 0))) begin
            a_cyc = c;
            a_valid[0] = (a_plan0.size() != 0) && (c >= st0);
            a_valid[1] = (a_plan1.size() != 0) && (c >= st1);
            if (a_plan0.size() != 0) {a_strb[0], a_data[0]} = a_plan0[0];
            if (a_plan1.size() != 0) {a_strb[1], a_data[1]} = a_plan1[0];
            a_pop_ready = !((c >= bp_lo) && (c <= bp_hi));
            @(negedge clk);
            if (a_tid == 1 && c == 1) chk("skew_rdy0_c1", a_ready[0], 1'b1);
            if (a_tid == 1 && c == 2) chk("skew_rdy0_c2", a_ready[0], 1'b0);
            if (a_tid == 1 && c == 5) chk("skew_noval_c5", a_pop_valid, 1'b0);
            if (a_tid == 2 && c == 6) chk("bp_rdy_low", a_ready, 2'b00);
            if (a_tid == 2 && c == 6) chk("bp_valid_hi", a_pop_valid, 1'b1);
            acc0 = a_valid[0] && a_ready[0];
            acc1 = a_valid[1] && a_ready[1];
            @(posedge clk); #1;
            if (acc0) a_plan0.delete(0);
            if (acc1) a_plan1.delete(0);
            c++;
        end
        a_valid = 2'b00;
        a_pop_ready = 1'b1;
        chk("a_run_done", (a_plan0.size() == 0) && (a_plan1.size() == 0) && (a_exp_q.size() == 0), 1'b1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d0, d1;
        logic [3:0]  s0, s1;
        int          bidx [4];
        int          c;
        logic        busy, accb [4];

        rst_n = 1'b0;
        a_clear = 1'b0; a_valid = 2'b00; a_data = '0; a_strb = '0; a_pop_ready = 1'b1;
        b_clear = 1'b0; b_valid = 4'b0000; b_data = '0; b_strb = '0; b_pop_ready = 1'b1;

        // Reset values, held for three cycles and checked on the first cycle after release
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_a_valid", a_pop_valid, 1'b0);
            chk("rst_a_data", {a_pop_strb, a_pop_data}, 72'h0);
            chk("rst_a_ready", a_ready, 2'b11);
            chk("rst_b_valid", b_pop_valid, 1'b0);
            chk("rst_b_data", {b_pop_strb, b_pop_data}, 144'h0);
            chk("rst_b_ready", b_ready, 4'b1111);
            @(posedge clk); #1;
            if (i == 2) rst_n = 1'b1;
        end
        a_mon_en = 1'b1;

        // Skewed lanes: lane 0 from cycle 0, lane 1 from cycle 5
        a_tid = 1;
        for (int k = 0; k < 4; k++) begin
            d0 = 32'(k);
            d1 = 32'h1111_1111 * 32'(k + 1);
            a_plan0.push_back({4'hF, d0});
            a_plan1.push_back({4'b0101, d1});
            a_exp_q.push_back({4'b0101, 4'hF, d1, d0});
        end
        run_a(0, 5, -1, -1, 60);
        chk("skew_first_cyc", a_first_cyc, 6);
        chk("skew_out_cnt", a_out_cnt, 4);

        // Backpressure: pop_ready low on cycles 4..9
        a_tid = 2;
        for (int k = 0; k < 8; k++) begin
            d0 = 32'hA000_0000 + 32'(k);
            d1 = 32'hB000_0000 + 32'(k);
            s1 = 4'(k);
            a_plan0.push_back({4'hF, d0});
            a_plan1.push_back({s1, d1});
            a_exp_q.push_back({s1, 4'hF, d1, d0});
        end
        run_a(0, 0, 4, 9, 80);
        chk("bp_out_cnt", a_out_cnt, 8);

        // Full-throughput streaming with random data and strobes
        a_tid = 3;
        for (int k = 0; k < 100; k++) begin
            d0 = $urandom; d1 = $urandom;
            s0 = 4'($urandom_range(0, 15)); s1 = 4'($urandom_range(0, 15));
            a_plan0.push_back({s0, d0});
            a_plan1.push_back({s1, d1});
            a_exp_q.push_back({s1, s0, d1, d0});
        end
        run_a(0, 0, -1, -1, 300);
        chk("tput_out_cnt", a_out_cnt, 100);
        chk("tput_first_cyc", a_first_cyc, 1);
        chk("tput_last_cyc", a_last_cyc, 100);

        // Clear while lane 0 is full and lane 1 is offering a beat
        a_tid = 4;
        a_exp_q.push_back({4'h3, 4'hC, 32'h7777_0001, 32'h6666_0001});
        a_valid = 2'b01; a_data[0] = 32'h5A5A_0001; a_strb[0] = 4'hF;
        @(negedge clk); chk("clr_fill_rdy", a_ready[0], 1'b1);
        @(posedge clk); #1; a_data[0] = 32'h5A5A_0002;
        @(negedge clk);
        @(posedge clk); #1; a_valid = 2'b00;
        @(negedge clk); chk("clr_pre_full", a_ready[0], 1'b0); chk("clr_pre_val", a_pop_valid, 1'b0);
        @(posedge clk); #1; a_clear = 1'b1; a_valid = 2'b10; a_data[1] = 32'hDEAD_BEEF; a_strb[1] = 4'hE;
        @(negedge clk); chk("clr_rdy_low", a_ready, 2'b00); chk("clr_val_low", a_pop_valid, 1'b0);
        @(posedge clk); #1; a_clear = 1'b0; a_valid = 2'b00;
        @(negedge clk); chk("clr_emptied", a_ready, 2'b11); chk("clr_post_val", a_pop_valid, 1'b0);
        @(posedge clk); #1; a_valid = 2'b10; a_data[1] = 32'h7777_0001; a_strb[1] = 4'h3;
        @(negedge clk);
        @(posedge clk); #1; a_valid = 2'b00;
        @(negedge clk); chk("clr_wait_val", a_pop_valid, 1'b0);
        @(posedge clk); #1; a_valid = 2'b01; a_data[0] = 32'h6666_0001; a_strb[0] = 4'hC;
        @(negedge clk);
        @(posedge clk); #1; a_valid = 2'b00;
        @(negedge clk); chk("clr_out_val", a_pop_valid, 1'b1);
        @(posedge clk); #1;
        @(negedge clk); chk("clr_drained", a_exp_q.size(), 0); chk("clr_end_val", a_pop_valid, 1'b0);
        @(posedge clk); #1;

        // Depth-1, four lanes, continuous input
        b_mon_en = 1'b1;
        b_out_cnt = 0; b_first_cyc = -1; b_prev_cyc = 0;
        for (int k = 0; k < 6; k++)
            b_exp_q.push_back({bstr(3, k), bstr(2, k), bstr(1, k), bstr(0, k),
                               bdat(3, k), bdat(2, k), bdat(1, k), bdat(0, k)});
        for (int l = 0; l < 4; l++) bidx[l] = 0;
        c = 0;
        busy = 1'b1;
        while ((c < 40) && busy) begin
            b_cyc = c;
            for (int l = 0; l < 4; l++) begin
                b_valid[l] = (bidx[l] < 6);
                b_data[l]  = bdat(l, bidx[l]);
                b_strb[l]  = bstr(l, bidx[l]);
            end
            @(negedge clk);
            if (c == 1) chk("d1_full_rdy", b_ready, 4'b0000);
            for (int l = 0; l < 4; l++) accb[l] = b_valid[l] && b_ready[l];
            @(posedge clk); #1;
            busy = (b_exp_q.size() != 0);
            for (int l = 0; l < 4; l++) begin
                if (accb[l]) bidx[l]++;
                if (bidx[l] < 6) busy = 1'b1;
            end
            c++;
        end
        b_valid = 4'b0000;
        chk("d1_done", busy, 1'b0);
        chk("d1_out_cnt", b_out_cnt, 6);
        chk("d1_first_cyc", b_first_cyc, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
